// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter_if
//  Purpose  : Producer-side result channels and broadcast-side bus signals
//             of the common-data-bus arbiter, bundled for port connection.
//  Revision : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
   parameter int NUM_SRC = 4,
   parameter int NUM_BUS = 2,
   parameter int DATA_W  = 32,
   parameter int ROB_W   = 3
);
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC-1:0]        src_ready;
   logic [NUM_SRC*ROB_W-1:0]  src_robNum;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [NUM_BUS-1:0]        iscast_out;
   logic [NUM_BUS*ROB_W-1:0]  robNum_out;
   logic [NUM_BUS*DATA_W-1:0] data_out;

   // Producers and bus consumers
   modport master (
      output src_valid, src_robNum, src_data,
      input  src_ready, iscast_out, robNum_out, data_out
   );

   // The arbiter itself
   modport slave (
      input  src_valid, src_robNum, src_data,
      output src_ready, iscast_out, robNum_out, data_out
   );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Buffers results from NUM_SRC functional units in per-source
//             FIFOs and broadcasts up to NUM_BUS of them per cycle on the
//             common data bus, granting sources in round-robin order.
//  Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int NUM_BUS    = 2,
   parameter int DATA_W     = 32,
   parameter int ROB_W      = 3,
   parameter int FIFO_DEPTH = 2
) (
   input  wire logic        clock,
   input  wire logic        reset,
   input  wire logic        flush,
   cdb_arbiter_if.slave     bus,
   output logic [15:0]      contention_cnt
);

   localparam int C_PTR_W = $clog2(FIFO_DEPTH);
   localparam int C_CNT_W = C_PTR_W + 1;
   localparam int C_SRC_W = $clog2(NUM_SRC);
   localparam int C_ENT_W = ROB_W + DATA_W;

   // FIFO storage: entry layout is {robNum, data}
   logic [C_ENT_W-1:0] r_mem   [NUM_SRC][FIFO_DEPTH];
   logic [C_PTR_W-1:0] r_wptr  [NUM_SRC];
   logic [C_PTR_W-1:0] r_rptr  [NUM_SRC];
   logic [C_CNT_W-1:0] r_count [NUM_SRC];

   logic [C_SRC_W-1:0]        r_rr;
   logic [NUM_BUS-1:0]        r_cast;
   logic [NUM_BUS*ROB_W-1:0]  r_rob;
   logic [NUM_BUS*DATA_W-1:0] r_data;
   logic [15:0]               r_cont;

   logic [NUM_SRC-1:0] w_nonempty;
   logic [NUM_SRC-1:0] w_ready;
   logic [NUM_SRC-1:0] w_push;
   logic [NUM_SRC-1:0] w_pop;
   logic [C_ENT_W-1:0] w_head    [NUM_SRC];
   logic [NUM_BUS-1:0] w_bus_vld;
   logic [C_SRC_W-1:0] w_bus_src [NUM_BUS];
   logic [C_ENT_W-1:0] w_bus_ent [NUM_BUS];
   logic [C_SRC_W-1:0] w_next_rr;
   logic               w_contend;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign w_nonempty[i] = (r_count[i] != '0);
      // Ready looks only at occupancy; a full FIFO stays not-ready even while popping
      assign w_ready[i]    = (r_count[i] < C_CNT_W'(FIFO_DEPTH));
      assign w_push[i]     = bus.src_valid[i] & w_ready[i] & ~flush;
      assign w_head[i]     = r_mem[i][r_rptr[i]];
   end

   assign bus.src_ready  = w_ready;
   assign bus.iscast_out = r_cast;
   assign bus.robNum_out = r_rob;
   assign bus.data_out   = r_data;
   assign contention_cnt = r_cont;

   // Round-robin scan from r_rr: the first NUM_BUS non-empty sources get buses in scan order
   always_comb begin
      int idx;
      int ngrant;
      w_pop     = '0;
      w_bus_vld = '0;
      w_next_rr = r_rr;
      ngrant    = 0;
      for (int k = 0; k < NUM_BUS; k++) begin
         w_bus_src[k] = '0;
      end
      for (int j = 0; j < NUM_SRC; j++) begin
         idx = int'(r_rr) + j;
         if (idx >= NUM_SRC) begin
            idx = idx - NUM_SRC;
         end
         if (w_nonempty[idx] && (ngrant < NUM_BUS)) begin
            w_pop[idx]        = 1'b1;
            w_bus_vld[ngrant] = 1'b1;
            w_bus_src[ngrant] = C_SRC_W'(idx);
            w_next_rr         = (idx == NUM_SRC - 1) ? '0 : C_SRC_W'(idx + 1);
            ngrant            = ngrant + 1;
         end
      end
   end

   // Head entry selected for each bus, plus contention detection
   always_comb begin
      int nonempty_cnt;
      nonempty_cnt = 0;
      for (int k = 0; k < NUM_BUS; k++) begin
         w_bus_ent[k] = w_head[w_bus_src[k]];
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_nonempty[i]) begin
            nonempty_cnt = nonempty_cnt + 1;
         end
      end
      w_contend = (nonempty_cnt > NUM_BUS);
   end

   // FIFO data array; contents need no reset since occupancy gates every read
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_push[i]) begin
            r_mem[i][r_wptr[i]] <= {bus.src_robNum[i*ROB_W +: ROB_W],
                                    bus.src_data[i*DATA_W +: DATA_W]};
         end
      end
   end

   // FIFO pointers and occupancy; flush empties every FIFO
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            r_wptr[i]  <= '0;
            r_rptr[i]  <= '0;
            r_count[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (flush) begin
               r_wptr[i]  <= '0;
               r_rptr[i]  <= '0;
               r_count[i] <= '0;
            end else begin
               if (w_push[i]) begin
                  r_wptr[i] <= r_wptr[i] + 1'b1;
               end
               if (w_pop[i]) begin
                  r_rptr[i] <= r_rptr[i] + 1'b1;
               end
               r_count[i] <= r_count[i] + C_CNT_W'(w_push[i]) - C_CNT_W'(w_pop[i]);
            end
         end
      end
   end

   // Broadcast registers: valid for one cycle, payload holds when a bus is idle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cast <= '0;
         r_rob  <= '0;
         r_data <= '0;
      end else if (flush) begin
         r_cast <= '0;
      end else begin
         for (int k = 0; k < NUM_BUS; k++) begin
            r_cast[k] <= w_bus_vld[k];
            if (w_bus_vld[k]) begin
               r_rob[k*ROB_W +: ROB_W]    <= w_bus_ent[k][C_ENT_W-1 -: ROB_W];
               r_data[k*DATA_W +: DATA_W] <= w_bus_ent[k][DATA_W-1:0];
            end
         end
      end
   end

   // Round-robin pointer and saturating contention counter; both frozen by flush
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rr   <= '0;
         r_cont <= '0;
      end else if (!flush) begin
         if (|w_bus_vld) begin
            r_rr <= w_next_rr;
         end
         if (w_contend && (r_cont != 16'hFFFF)) begin
            r_cont <= r_cont + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire
